// File: rtl/img_pkg.sv
`default_nettype none
// ============================================================================
// Module   : img_pkg
// Purpose  : Frame geometry and controller state encoding. These values are
//            shared by the line buffer, its controller and the conv stage.
// Revision : 1.0 - initial release
// ============================================================================
package img_pkg;

  localparam int PIX_W = 12;
  localparam int IMG_W = 640;
  localparam int IMG_H = 480;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } ctrl_state_t;

endpackage : img_pkg
`default_nettype wire

// File: rtl/image_buffer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : image_buffer_ctrl_if
// Purpose  : Pixel-in / window-out handshake and buffer-control bundle.
//            The master side is the environment (source and kernel).
//            The slave side is the sequencing controller.
// Revision : 1.0 - initial release
// ============================================================================
interface image_buffer_ctrl_if #(
  parameter int COL_W = 10,
  parameter int ROW_W = 9
);
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic             out_ready;
  logic             buf_en;
  logic             buf_pixel_valid;
  logic             buf_pixel_edge;
  logic             win_valid;
  logic [ROW_W-1:0] win_row;
  logic [COL_W-1:0] win_col;
  logic             busy;
  logic             frame_done;

  modport master (
    output start, in_valid, out_ready,
    input  in_ready, buf_en, buf_pixel_valid, buf_pixel_edge,
           win_valid, win_row, win_col, busy, frame_done
  );

  modport slave (
    input  start, in_valid, out_ready,
    output in_ready, buf_en, buf_pixel_valid, buf_pixel_edge,
           win_valid, win_row, win_col, busy, frame_done
  );
endinterface : image_buffer_ctrl_if
`default_nettype wire

// File: rtl/image_buffer_ctrl_pos_counter.sv
`default_nettype none
// ============================================================================
// Module   : img_pos_counter
// Purpose  : Raster column/row position counter. It has an increment enable,
//            a synchronous clear, and end-of-row / end-of-frame flags.
//            The row counter saturates on the last row. Frame end is handled
//            by the owner of this counter.
// Revision : 1.0 - initial release
// ============================================================================
module img_pos_counter #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int COL_W = $clog2(IMG_W),
  parameter int ROW_W = $clog2(IMG_H)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o,
  output logic             eol_o,
  output logic             eof_o
);
  import img_pkg::*;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;

  assign eol_o = (col_q == COL_LAST);
  assign eof_o = eol_o && (row_q == ROW_LAST);
  assign col_o = col_q;
  assign row_o = row_q;

  // Advance position on each increment; clear has priority over increment.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      col_q <= '0;
      row_q <= '0;
    end else if (inc_i) begin
      if (eol_o) begin
        col_q <= '0;
        if (!eof_o) begin
          row_q <= row_q + ROW_W'(1);
        end
      end else begin
        col_q <= col_q + COL_W'(1);
      end
    end
  end

endmodule : img_pos_counter
`default_nettype wire

// File: rtl/image_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : image_buffer_ctrl
// Purpose  : Frame sequencer for the 3-row line buffer. It accepts the pixel
//            stream, drives the buffer shift enable and pixel qualifiers, and
//            holds windows back until two rows are primed. It presents a
//            single-entry window slice to the 3x3 convolution stage.
// Revision : 1.0 - initial release
// ============================================================================
module image_buffer_ctrl #(
  parameter int IMG_W = img_pkg::IMG_W,
  parameter int IMG_H = img_pkg::IMG_H,
  parameter int COL_W = $clog2(IMG_W),
  parameter int ROW_W = $clog2(IMG_H)
) (
  input  logic               clk,
  input  logic               rst,
  image_buffer_ctrl_if.slave ctrl_io
);
  import img_pkg::*;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  ctrl_state_t      state_q, state_d;
  logic             busy_q;
  logic             win_valid_q;
  logic [ROW_W-1:0] win_row_q;
  logic [COL_W-1:0] win_col_q;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             eol, eof;
  logic             clr;
  logic             drain_exit;
  logic             in_ready;
  logic             buf_en;
  logic             win_load;

  img_pos_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_pos (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr),
    .inc_i (buf_en),
    .col_o (col),
    .row_o (row),
    .eol_o (eol),
    .eof_o (eof)
  );

  // The buffer only shifts when the window slice is empty or is being drained,
  // so a stalled window is never overwritten.
  assign in_ready = ((state_q == PRIME) || (state_q == RUN)) &&
                    (!win_valid_q || ctrl_io.out_ready);
  assign buf_en   = ctrl_io.in_valid && in_ready;
  assign win_load = buf_en && (row >= ROW_W'(2)) && (col >= COL_W'(2));

  assign ctrl_io.in_ready        = in_ready;
  assign ctrl_io.buf_en          = buf_en;
  assign ctrl_io.buf_pixel_valid = buf_en;
  assign ctrl_io.buf_pixel_edge  = buf_en && ((col == '0) || (col == COL_LAST) ||
                                              (row == '0) || (row == ROW_LAST));
  assign ctrl_io.win_valid       = win_valid_q;
  assign ctrl_io.win_row         = win_row_q;
  assign ctrl_io.win_col         = win_col_q;
  assign ctrl_io.busy            = busy_q;
  // The frame_done pulse must coincide with the cycle in which the last window
  // is taken. So it is decoded from the registered DRAIN state and the live
  // out_ready, not taken from a separate flop.
  assign ctrl_io.frame_done      = drain_exit;

  // State register and registered busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  // Next-state decode: priming, running, draining the final window.
  always_comb begin
    state_d    = state_q;
    clr        = 1'b0;
    drain_exit = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_io.start) begin
          clr     = 1'b1;
          state_d = PRIME;
        end
      end
      PRIME: begin
        if (buf_en && (row == ROW_W'(1)) && eol) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (buf_en && eof) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!win_valid_q || ctrl_io.out_ready) begin
          drain_exit = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Window slice: a load replaces the current window; otherwise a consume empties it.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else if (win_load) begin
      win_valid_q <= 1'b1;
      win_row_q   <= row - ROW_W'(1);
      win_col_q   <= col - COL_W'(1);
    end else if (win_valid_q && ctrl_io.out_ready) begin
      win_valid_q <= 1'b0;
    end
  end

endmodule : image_buffer_ctrl
`default_nettype wire

// File: tb/tb_image_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_image_buffer_ctrl
// Purpose  : Directed bench for the line-buffer sequencer. It uses a 4x4 frame
//            instance and a 16x8 instance driven with random handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_image_buffer_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  image_buffer_ctrl_if #(.COL_W(2), .ROW_W(2)) bus ();
  image_buffer_ctrl_if #(.COL_W(4), .ROW_W(3)) bus2 ();

  image_buffer_ctrl #(.IMG_W(4), .IMG_H(4), .COL_W(2), .ROW_W(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .ctrl_io (bus)
  );

  image_buffer_ctrl #(.IMG_W(16), .IMG_H(8), .COL_W(4), .ROW_W(3)) dut2 (
    .clk     (clk),
    .rst     (rst),
    .ctrl_io (bus2)
  );

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.start = 1'b0;  bus.in_valid = 1'b0;  bus.out_ready = 1'b0;
    bus2.start = 1'b0; bus2.in_valid = 1'b0; bus2.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic start_frame();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  // Push n pixels through while the controller is known to be ready.
  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] obs;
    apply_reset();
    bus.in_valid = 1'b1;
    #1;
    obs = {bus.in_ready, bus.buf_en, bus.buf_pixel_valid, bus.buf_pixel_edge,
           bus.win_valid, bus.win_row, bus.win_col, bus.busy, bus.frame_done};
    checks++;
    if (obs !== 13'h0) begin
      errors++; $display("FAIL reset_state: got %h want 0", obs);
    end
    step(); step();
    checks++;
    if ({bus.buf_en, bus.busy} !== 2'b00) begin
      errors++; $display("FAIL idle_input: buf_en/busy got %b want 00", {bus.buf_en, bus.busy});
    end
    // Reset in the middle of RUN while a window is stalled.
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    start_frame();
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL busy_after_start: got %b want 1", bus.busy);
    end
    feed(11);
    checks++;
    if ({bus.win_valid, bus.win_row, bus.win_col} !== 5'b1_01_01) begin
      errors++; $display("FAIL pre_reset_window: got %b want 10101", {bus.win_valid, bus.win_row, bus.win_col});
    end
    rst = 1'b1;
    bus.in_valid = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    obs = {bus.in_ready, bus.buf_en, bus.buf_pixel_valid, bus.buf_pixel_edge,
           bus.win_valid, bus.win_row, bus.win_col, bus.busy, bus.frame_done};
    checks++;
    if (obs !== 13'h0) begin
      errors++; $display("FAIL midrun_reset: got %h want 0", obs);
    end
    step();
    checks++;
    if ({bus.frame_done, bus.busy, bus.buf_en} !== 3'b000) begin
      errors++; $display("FAIL midrun_reset_no_done: got %b want 000", {bus.frame_done, bus.busy, bus.buf_en});
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_priming();
    apply_reset();
    bus.out_ready = 1'b1;
    start_frame();
    for (int k = 1; k <= 11; k++) begin
      bus.in_valid = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++; $display("FAIL prime_ready k=%0d: got %b want 1", k, bus.in_ready);
      end
      step();
      if (k <= 10) begin
        checks++;
        if (bus.win_valid !== 1'b0) begin
          errors++; $display("FAIL prime_no_window k=%0d: got %b want 0", k, bus.win_valid);
        end
      end else begin
        checks++;
        if ({bus.win_valid, bus.win_row, bus.win_col} !== 5'b1_01_01) begin
          errors++; $display("FAIL prime_first_window: got %b want 10101", {bus.win_valid, bus.win_row, bus.win_col});
        end
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_full_rate();
    int acc = 0, edges = 0, nwin = 0, dones = 0, done_cyc = -1;
    int wr[8], wc[8];
    int er[4] = '{1, 1, 2, 2};
    int ec[4] = '{1, 2, 1, 2};
    apply_reset();
    bus.out_ready = 1'b1;
    start_frame();
    for (int cyc = 0; cyc < 20; cyc++) begin
      bus.in_valid = 1'b1;
      bus.start    = (cyc == 16);
      #1;
      if (bus.buf_en) begin
        acc++;
        if (bus.buf_pixel_edge) edges++;
      end
      if (bus.win_valid && bus.out_ready && nwin < 8) begin
        wr[nwin] = int'(bus.win_row);
        wc[nwin] = int'(bus.win_col);
        nwin++;
      end
      if (bus.frame_done) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      step();
    end
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if (acc !== 16) begin errors++; $display("FAIL full_accepts: got %0d want 16", acc); end
    checks++;
    if (edges !== 12) begin errors++; $display("FAIL full_edges: got %0d want 12", edges); end
    checks++;
    if (nwin !== 4) begin errors++; $display("FAIL full_windows: got %0d want 4", nwin); end
    for (int i = 0; i < 4; i++) begin
      if (i < nwin) begin
        checks++;
        if (wr[i] !== er[i] || wc[i] !== ec[i]) begin
          errors++; $display("FAIL full_centre %0d: got (%0d,%0d) want (%0d,%0d)", i, wr[i], wc[i], er[i], ec[i]);
        end
      end
    end
    checks++;
    if (done_cyc !== 16 || dones !== 1) begin
      errors++; $display("FAIL full_frame_done: got cycle %0d count %0d want cycle 16 count 1", done_cyc, dones);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL start_at_done_ignored: busy got %b want 0", bus.busy);
    end
  endtask

  task automatic test_backpressure();
    int acc = 0, nwin = 0;
    bit done = 1'b0;
    int wr[8], wc[8];
    int er[4] = '{1, 1, 2, 2};
    int ec[4] = '{1, 2, 1, 2};
    apply_reset();
    bus.out_ready = 1'b1;
    start_frame();
    feed(11);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({bus.in_ready, bus.buf_en, bus.win_valid, bus.win_row, bus.win_col} !== 7'b00_1_01_01) begin
        errors++; $display("FAIL stall cycle %0d: got %b want 0010101", i,
                           {bus.in_ready, bus.buf_en, bus.win_valid, bus.win_row, bus.win_col});
      end
      step();
    end
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 30 && !done; cyc++) begin
      bus.in_valid = 1'b1;
      #1;
      if (bus.buf_en) acc++;
      if (bus.win_valid && bus.out_ready && nwin < 8) begin
        wr[nwin] = int'(bus.win_row);
        wc[nwin] = int'(bus.win_col);
        nwin++;
      end
      if (bus.frame_done) done = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (!done) begin errors++; $display("FAIL bp_frame_done: got timeout want pulse"); end
    checks++;
    if (acc !== 5) begin errors++; $display("FAIL bp_accepts: got %0d want 5", acc); end
    checks++;
    if (nwin !== 4) begin errors++; $display("FAIL bp_windows: got %0d want 4", nwin); end
    for (int i = 0; i < 4; i++) begin
      if (i < nwin) begin
        checks++;
        if (wr[i] !== er[i] || wc[i] !== ec[i]) begin
          errors++; $display("FAIL bp_centre %0d: got (%0d,%0d) want (%0d,%0d)", i, wr[i], wc[i], er[i], ec[i]);
        end
      end
    end
  endtask

  task automatic test_ignored_start();
    apply_reset();
    bus.out_ready = 1'b1;
    start_frame();
    feed(10);
    bus.start = 1'b1;
    bus.in_valid = 1'b1;
    step();
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if ({bus.win_valid, bus.win_row, bus.win_col} !== 5'b1_01_01) begin
      errors++; $display("FAIL start_in_run_accept: got %b want 10101", {bus.win_valid, bus.win_row, bus.win_col});
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    checks++;
    if ({bus.win_valid, bus.win_row, bus.win_col, bus.busy} !== 6'b1_01_10_1) begin
      errors++; $display("FAIL start_in_run_counters: got %b want 101101",
                         {bus.win_valid, bus.win_row, bus.win_col, bus.busy});
    end
  endtask

  task automatic test_random_frame();
    int acc = 0, nwin = 0, er = 1, ec = 1;
    bit done = 1'b0;
    apply_reset();
    bus2.start = 1'b1;
    step();
    bus2.start = 1'b0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      bus2.in_valid  = ($urandom_range(0, 3) != 0);
      bus2.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus2.buf_en) acc++;
      if (bus2.win_valid && bus2.out_ready) begin
        checks++;
        if (int'(bus2.win_row) !== er || int'(bus2.win_col) !== ec) begin
          errors++; $display("FAIL rnd_centre %0d: got (%0d,%0d) want (%0d,%0d)", nwin,
                             bus2.win_row, bus2.win_col, er, ec);
        end
        nwin++;
        if (ec == 14) begin ec = 1; er++; end
        else ec++;
      end
      if (bus2.frame_done) done = 1'b1;
      step();
    end
    bus2.in_valid = 1'b0;
    bus2.out_ready = 1'b0;
    checks++;
    if (!done) begin errors++; $display("FAIL rnd_frame_done: got timeout want pulse"); end
    checks++;
    if (nwin !== 84) begin errors++; $display("FAIL rnd_windows: got %0d want 84", nwin); end
    checks++;
    if (acc !== 128) begin errors++; $display("FAIL rnd_accepts: got %0d want 128", acc); end
    checks++;
    if (bus2.busy !== 1'b0) begin errors++; $display("FAIL rnd_idle_after: busy got %b want 0", bus2.busy); end
  endtask

  initial begin
    test_reset();
    test_priming();
    test_full_rate();
    test_backpressure();
    test_ignored_start();
    test_random_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_image_buffer_ctrl
`default_nettype wire
